z80fi_capture: RTL and testbench
================================

// Module: z80fi_capture
// PURPOSE
// - Upstream of the z80fi_insn_spec_* checkers. Turns core execution events into one
//   retired-instruction record on the Z80FI bus.
// - Accumulates opcode bytes, up to two data memory reads and register snapshots.
// - Pulses z80fi_valid for 1 cycle per retired instruction.
// PARAMETERS
// - INSN_BYTES  4  max opcode bytes kept; z80fi_insn width is 8*INSN_BYTES
// PORTS
// - clk             in   1   single clock; all state on rising edge
// - reset           in   1   async, active-high; clears all state
// - ev_start        in   1   first M1 of new insn; snapshot reg_*_now as *_in
// - ev_fetch        in   1   opcode/operand byte fetched this cycle
// - ev_fetch_byte   in   8   byte for ev_fetch
// - ev_mrd          in   1   data memory read completed
// - ev_mrd_addr     in   16  address of ev_mrd
// - ev_mrd_data     in   8   data of ev_mrd
// - ev_retire       in   1   insn finished; reg_*_now hold final values
// - reg_ip_now, reg_sp_now, reg_ix_now, reg_iy_now   in   16   live core registers
// - z80fi_valid     out  1   record valid, 1-cycle pulse
// - z80fi_insn      out  8*INSN_BYTES   byte k at [8k+7:8k], unused bytes 0
// - z80fi_insn_len  out  3   opcode bytes captured (saturates at INSN_BYTES)
// - z80fi_mem_raddr, z80fi_mem_raddr2    out  16   1st/2nd data read address
// - z80fi_mem_rdata, z80fi_mem_rdata2    out  8    1st/2nd data read data
// - z80fi_reg_{ip,sp,ix,iy}_in           out  16   snapshot at ev_start
// - z80fi_reg_{ip,sp,ix,iy}_out          out  16   snapshot at ev_retire
// - z80fi_overflow  out  1   with valid: >INSN_BYTES fetches or >2 reads seen
// BEHAVIOUR
// - FSM IDLE/CAPT. Reset -> IDLE; every output and internal register 0.
// - IDLE: ev_start -> CAPT. Latch *_in, clear byte/read counters, buffers, overflow.
//   ev_fetch/ev_mrd/ev_retire without a prior start are ignored.
// - ev_fetch in the same cycle as ev_start is captured as byte 0.
// - CAPT, ev_fetch: byte into slot fcnt, fcnt++.
//   fcnt==INSN_BYTES: byte dropped, overflow set, fcnt held.
// - CAPT, ev_mrd: rcnt 0 -> raddr/rdata, 1 -> raddr2/rdata2, >=2 -> dropped, overflow set.
// - ev_mrd in the same cycle as ev_start counts for the new insn.
// - CAPT, ev_retire: next cycle z80fi_valid=1 and the record is presented.
//   *_out = reg_*_now sampled at retire. The fetch/mrd of the retire cycle is included.
// - Latency: retire -> valid = 1 cycle. Record outputs hold until the next valid.
// - Retire + start in the same cycle: record closes as above.
//   A new capture begins (back-to-back): CAPT with *_in = reg_*_now.
//   The fetch of that cycle goes to the NEW insn's byte 0.
//   Retire-only -> IDLE.
// - ev_start while in CAPT without retire: current record abandoned, no valid.
//   Restart as from IDLE.
// - Async reset mid-capture: record discarded, no valid pulse, outputs 0.
// - Address arithmetic none; counters are 3-bit, saturating, never wrap.
// TESTING
// - POP IX: start(sp=FFF0,ix=0), fetch DD,E1, mrd(FFF0,34), mrd(FFF1,12), retire(sp=FFF2,ix=1234,ip+2)
//   -> 1 cycle later valid=1, insn=0000E1DD, len=2, raddr=FFF0, rdata2=12, ix_out=1234.
// - Back-to-back: retire+start+fetch 00 in one cycle
//   -> valid for insn A; insn B len counts byte 00 in slot 0; no lost pulse.
// - Overflow: 5 fetches, 3 reads -> len=4, insn bytes 1-4 only, rdata2=2nd read, overflow=1.
// - Orphans: fetch/mrd/retire in IDLE -> no valid, outputs unchanged.
// - Reset after start+2 fetches -> valid never asserts.
//   Outputs 0; next full insn records len from 0.
// - Restart: start, fetch CB, start, fetch 00, retire -> one valid, insn=00, len=1.

Source files
------------

// File: rtl/z80fi_capture.sv
// z80fi_capture: collects core execution events for one instruction and
// presents them as a single retired-instruction record on the Z80FI bus.
// A record holds the opcode bytes, up to two data reads, and register
// snapshots taken at start and at retire. Each retirement produces a
// one-cycle z80fi_valid pulse.

module z80fi_capture #(
  parameter int INSN_BYTES = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ev_start,
  input  logic                    ev_fetch,
  input  logic [7:0]              ev_fetch_byte,
  input  logic                    ev_mrd,
  input  logic [15:0]             ev_mrd_addr,
  input  logic [7:0]              ev_mrd_data,
  input  logic                    ev_retire,
  input  logic [15:0]             reg_ip_now,
  input  logic [15:0]             reg_sp_now,
  input  logic [15:0]             reg_ix_now,
  input  logic [15:0]             reg_iy_now,
  output logic                    z80fi_valid,
  output logic [8*INSN_BYTES-1:0] z80fi_insn,
  output logic [2:0]              z80fi_insn_len,
  output logic [15:0]             z80fi_mem_raddr,
  output logic [15:0]             z80fi_mem_raddr2,
  output logic [7:0]              z80fi_mem_rdata,
  output logic [7:0]              z80fi_mem_rdata2,
  output logic [15:0]             z80fi_reg_ip_in,
  output logic [15:0]             z80fi_reg_sp_in,
  output logic [15:0]             z80fi_reg_ix_in,
  output logic [15:0]             z80fi_reg_iy_in,
  output logic [15:0]             z80fi_reg_ip_out,
  output logic [15:0]             z80fi_reg_sp_out,
  output logic [15:0]             z80fi_reg_ix_out,
  output logic [15:0]             z80fi_reg_iy_out,
  output logic                    z80fi_overflow
);

  localparam logic [2:0] MAX_BYTES = 3'(INSN_BYTES);

  typedef enum logic {IDLE, CAPT} state_e;

  state_e                  state_q, state_d;
  logic [8*INSN_BYTES-1:0] insn_q, insn_d;
  logic [2:0]              fcnt_q, fcnt_d;
  logic [2:0]              rcnt_q, rcnt_d;
  logic [15:0]             raddr_q, raddr_d, raddr2_q, raddr2_d;
  logic [7:0]              rdata_q, rdata_d, rdata2_q, rdata2_d;
  logic                    ovf_q, ovf_d;
  logic [15:0]             ipIn_q, ipIn_d, spIn_q, spIn_d;
  logic [15:0]             ixIn_q, ixIn_d, iyIn_q, iyIn_d;

  logic                    valid_q;
  logic [8*INSN_BYTES-1:0] recInsn_q;
  logic [2:0]              recLen_q;
  logic [15:0]             recRaddr_q, recRaddr2_q;
  logic [7:0]              recRdata_q, recRdata2_q;
  logic [15:0]             recIpIn_q, recSpIn_q, recIxIn_q, recIyIn_q;
  logic [15:0]             recIpOut_q, recSpOut_q, recIxOut_q, recIyOut_q;
  logic                    recOvf_q;

  logic                    closeRec;
  logic                    capturing;

  // A record closes whenever an open capture sees retire; with a
  // simultaneous start, that cycle's fetch/read belong to the new insn.
  assign closeRec  = (state_q == CAPT) && ev_retire;
  assign capturing = ev_start || (state_q == CAPT);

  // Next-state of the capture buffers: optional restart, then apply this cycle's events.
  always_comb begin
    state_d  = state_q;
    insn_d   = insn_q;
    fcnt_d   = fcnt_q;
    rcnt_d   = rcnt_q;
    raddr_d  = raddr_q;
    rdata_d  = rdata_q;
    raddr2_d = raddr2_q;
    rdata2_d = rdata2_q;
    ovf_d    = ovf_q;
    ipIn_d   = ipIn_q;
    spIn_d   = spIn_q;
    ixIn_d   = ixIn_q;
    iyIn_d   = iyIn_q;

    if (ev_start) begin
      state_d  = CAPT;
      insn_d   = '0;
      fcnt_d   = 3'd0;
      rcnt_d   = 3'd0;
      raddr_d  = 16'h0000;
      rdata_d  = 8'h00;
      raddr2_d = 16'h0000;
      rdata2_d = 8'h00;
      ovf_d    = 1'b0;
      ipIn_d   = reg_ip_now;
      spIn_d   = reg_sp_now;
      ixIn_d   = reg_ix_now;
      iyIn_d   = reg_iy_now;
    end else if (closeRec) begin
      state_d = IDLE;
    end

    if (capturing) begin
      if (ev_fetch) begin
        if (fcnt_d >= MAX_BYTES) begin
          ovf_d = 1'b1;
        end else begin
          for (int k = 0; k < INSN_BYTES; k++) begin
            if (fcnt_d == 3'(k)) begin
              insn_d[8*k +: 8] = ev_fetch_byte;
            end
          end
          fcnt_d = fcnt_d + 3'd1;
        end
      end
      if (ev_mrd) begin
        case (rcnt_d)
          3'd0: begin
            raddr_d = ev_mrd_addr;
            rdata_d = ev_mrd_data;
            rcnt_d  = 3'd1;
          end
          3'd1: begin
            raddr2_d = ev_mrd_addr;
            rdata2_d = ev_mrd_data;
            rcnt_d   = 3'd2;
          end
          default: ovf_d = 1'b1;
        endcase
      end
    end
  end

  // Capture state, buffers and the registered output record.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      insn_q      <= '0;
      fcnt_q      <= 3'd0;
      rcnt_q      <= 3'd0;
      raddr_q     <= 16'h0000;
      rdata_q     <= 8'h00;
      raddr2_q    <= 16'h0000;
      rdata2_q    <= 8'h00;
      ovf_q       <= 1'b0;
      ipIn_q      <= 16'h0000;
      spIn_q      <= 16'h0000;
      ixIn_q      <= 16'h0000;
      iyIn_q      <= 16'h0000;
      valid_q     <= 1'b0;
      recInsn_q   <= '0;
      recLen_q    <= 3'd0;
      recRaddr_q  <= 16'h0000;
      recRdata_q  <= 8'h00;
      recRaddr2_q <= 16'h0000;
      recRdata2_q <= 8'h00;
      recOvf_q    <= 1'b0;
      recIpIn_q   <= 16'h0000;
      recSpIn_q   <= 16'h0000;
      recIxIn_q   <= 16'h0000;
      recIyIn_q   <= 16'h0000;
      recIpOut_q  <= 16'h0000;
      recSpOut_q  <= 16'h0000;
      recIxOut_q  <= 16'h0000;
      recIyOut_q  <= 16'h0000;
    end else begin
      state_q  <= state_d;
      insn_q   <= insn_d;
      fcnt_q   <= fcnt_d;
      rcnt_q   <= rcnt_d;
      raddr_q  <= raddr_d;
      rdata_q  <= rdata_d;
      raddr2_q <= raddr2_d;
      rdata2_q <= rdata2_d;
      ovf_q    <= ovf_d;
      ipIn_q   <= ipIn_d;
      spIn_q   <= spIn_d;
      ixIn_q   <= ixIn_d;
      iyIn_q   <= iyIn_d;
      valid_q  <= closeRec;
      if (closeRec) begin
        recInsn_q   <= ev_start ? insn_q   : insn_d;
        recLen_q    <= ev_start ? fcnt_q   : fcnt_d;
        recRaddr_q  <= ev_start ? raddr_q  : raddr_d;
        recRdata_q  <= ev_start ? rdata_q  : rdata_d;
        recRaddr2_q <= ev_start ? raddr2_q : raddr2_d;
        recRdata2_q <= ev_start ? rdata2_q : rdata2_d;
        recOvf_q    <= ev_start ? ovf_q    : ovf_d;
        recIpIn_q   <= ipIn_q;
        recSpIn_q   <= spIn_q;
        recIxIn_q   <= ixIn_q;
        recIyIn_q   <= iyIn_q;
        recIpOut_q  <= reg_ip_now;
        recSpOut_q  <= reg_sp_now;
        recIxOut_q  <= reg_ix_now;
        recIyOut_q  <= reg_iy_now;
      end
    end
  end

  assign z80fi_valid      = valid_q;
  assign z80fi_insn       = recInsn_q;
  assign z80fi_insn_len   = recLen_q;
  assign z80fi_mem_raddr  = recRaddr_q;
  assign z80fi_mem_rdata  = recRdata_q;
  assign z80fi_mem_raddr2 = recRaddr2_q;
  assign z80fi_mem_rdata2 = recRdata2_q;
  assign z80fi_reg_ip_in  = recIpIn_q;
  assign z80fi_reg_sp_in  = recSpIn_q;
  assign z80fi_reg_ix_in  = recIxIn_q;
  assign z80fi_reg_iy_in  = recIyIn_q;
  assign z80fi_reg_ip_out = recIpOut_q;
  assign z80fi_reg_sp_out = recSpOut_q;
  assign z80fi_reg_ix_out = recIxOut_q;
  assign z80fi_reg_iy_out = recIyOut_q;
  assign z80fi_overflow   = recOvf_q;

endmodule

// File: tb/tb_z80fi_capture.sv
// Testbench for z80fi_capture: directed scenarios followed by random
// event streams, all compared against a queue-based model of a record.

module tb_z80fi_capture;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        evStart = 1'b0, evFetch = 1'b0, evMrd = 1'b0, evRetire = 1'b0;
  logic [7:0]  evFetchByte = 8'h00, evMrdData = 8'h00;
  logic [15:0] evMrdAddr = 16'h0000;
  logic [15:0] ipNow = 16'h0000, spNow = 16'h0000, ixNow = 16'h0000, iyNow = 16'h0000;

  logic        valid;
  logic [31:0] insn;
  logic [2:0]  insnLen;
  logic [15:0] raddr, raddr2;
  logic [7:0]  rdata, rdata2;
  logic [15:0] ipIn, spIn, ixIn, iyIn, ipOut, spOut, ixOut, iyOut;
  logic        overflow;

  int checks = 0;
  int errors = 0;
  int validCount = 0;

  // Reference model state
  logic [7:0]  fq[$];
  logic [23:0] rq[$];
  bit          mActive = 0;
  logic [15:0] mIn[4];
  logic        eValid;
  logic [31:0] eInsn;
  logic [2:0]  eLen;
  logic [15:0] eRa, eRa2;
  logic [7:0]  eRd, eRd2;
  logic [15:0] eIn[4], eOut[4];
  logic        eOvf;

  z80fi_capture #(.INSN_BYTES(4)) dut (
    .clk(clk), .reset(reset),
    .ev_start(evStart), .ev_fetch(evFetch), .ev_fetch_byte(evFetchByte),
    .ev_mrd(evMrd), .ev_mrd_addr(evMrdAddr), .ev_mrd_data(evMrdData),
    .ev_retire(evRetire),
    .reg_ip_now(ipNow), .reg_sp_now(spNow), .reg_ix_now(ixNow), .reg_iy_now(iyNow),
    .z80fi_valid(valid), .z80fi_insn(insn), .z80fi_insn_len(insnLen),
    .z80fi_mem_raddr(raddr), .z80fi_mem_raddr2(raddr2),
    .z80fi_mem_rdata(rdata), .z80fi_mem_rdata2(rdata2),
    .z80fi_reg_ip_in(ipIn), .z80fi_reg_sp_in(spIn),
    .z80fi_reg_ix_in(ixIn), .z80fi_reg_iy_in(iyIn),
    .z80fi_reg_ip_out(ipOut), .z80fi_reg_sp_out(spOut),
    .z80fi_reg_ix_out(ixOut), .z80fi_reg_iy_out(iyOut),
    .z80fi_overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic modelClear();
    fq.delete();
    rq.delete();
    mActive = 0;
    eValid = 0; eInsn = '0; eLen = '0; eRa = '0; eRa2 = '0; eRd = '0; eRd2 = '0; eOvf = 0;
    for (int i = 0; i < 4; i++) begin
      mIn[i] = '0; eIn[i] = '0; eOut[i] = '0;
    end
  endtask

  task automatic modelPush(input bit f, input logic [7:0] fb, input bit m,
                           input logic [15:0] ma, input logic [7:0] md);
    if (f) fq.push_back(fb);
    if (m) rq.push_back({ma, md});
  endtask

  // The record is whatever was collected, truncated to the bus capacity.
  task automatic modelBuild();
    int n;
    n = fq.size();
    eLen = (n > 4) ? 3'd4 : 3'(n);
    eInsn = '0;
    for (int i = 0; i < n && i < 4; i++) eInsn[8*i +: 8] = fq[i];
    eRa  = (rq.size() > 0) ? rq[0][23:8] : 16'h0;
    eRd  = (rq.size() > 0) ? rq[0][7:0]  : 8'h0;
    eRa2 = (rq.size() > 1) ? rq[1][23:8] : 16'h0;
    eRd2 = (rq.size() > 1) ? rq[1][7:0]  : 8'h0;
    eOvf = (n > 4) || (rq.size() > 2);
    eIn  = mIn;
    eOut[0] = ipNow; eOut[1] = spNow; eOut[2] = ixNow; eOut[3] = iyNow;
  endtask

  task automatic checkOutput(input string tag);
    checkValue({tag, ".valid"}, 32'(valid), 32'(eValid));
    checkValue({tag, ".insn"}, insn, eInsn);
    checkValue({tag, ".len"}, 32'(insnLen), 32'(eLen));
    checkValue({tag, ".raddr"}, 32'(raddr), 32'(eRa));
    checkValue({tag, ".rdata"}, 32'(rdata), 32'(eRd));
    checkValue({tag, ".raddr2"}, 32'(raddr2), 32'(eRa2));
    checkValue({tag, ".rdata2"}, 32'(rdata2), 32'(eRd2));
    checkValue({tag, ".ovf"}, 32'(overflow), 32'(eOvf));
    checkValue({tag, ".in"}, {ipIn, spIn}, {eIn[0], eIn[1]});
    checkValue({tag, ".in2"}, {ixIn, iyIn}, {eIn[2], eIn[3]});
    checkValue({tag, ".out"}, {ipOut, spOut}, {eOut[0], eOut[1]});
    checkValue({tag, ".out2"}, {ixOut, iyOut}, {eOut[2], eOut[3]});
  endtask

  // One clock of events; model advances at the edge, outputs checked 1 time unit later.
  task automatic applyStimulus(input string tag, input bit st, input bit f, input logic [7:0] fb,
                               input bit m, input logic [15:0] ma, input logic [7:0] md,
                               input bit rt);
    bit closing;
    @(negedge clk);
    evStart = st; evFetch = f; evFetchByte = fb;
    evMrd = m; evMrdAddr = ma; evMrdData = md; evRetire = rt;
    @(posedge clk);
    closing = mActive && rt;
    eValid = closing;
    if (closing && !st) modelPush(f, fb, m, ma, md);
    if (closing) begin
      modelBuild();
      mActive = 0;
    end
    if (st) begin
      fq.delete();
      rq.delete();
      mIn[0] = ipNow; mIn[1] = spNow; mIn[2] = ixNow; mIn[3] = iyNow;
      mActive = 1;
      modelPush(f, fb, m, ma, md);
    end else if (mActive) begin
      modelPush(f, fb, m, ma, md);
    end
    #1;
    if (valid === 1'b1) validCount++;
    checkOutput(tag);
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    modelClear();
    checkOutput("reset");
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int startCount;
    modelClear();
    #1;
    checkOutput("por");
    @(negedge clk);
    reset = 1'b0;

    // POP IX
    ipNow = 16'h0100; spNow = 16'hFFF0; ixNow = 16'h0000; iyNow = 16'h5555;
    applyStimulus("popix", 1, 1, 8'hDD, 0, 16'h0, 8'h0, 0);
    applyStimulus("popix", 0, 1, 8'hE1, 0, 16'h0, 8'h0, 0);
    applyStimulus("popix", 0, 0, 8'h00, 1, 16'hFFF0, 8'h34, 0);
    applyStimulus("popix", 0, 0, 8'h00, 1, 16'hFFF1, 8'h12, 0);
    ipNow = 16'h0102; spNow = 16'hFFF2; ixNow = 16'h1234;
    applyStimulus("popix", 0, 0, 8'h00, 0, 16'h0, 8'h0, 1);
    checkValue("popix.const.valid", 32'(valid), 32'd1);
    checkValue("popix.const.insn", insn, 32'h0000E1DD);
    checkValue("popix.const.len", 32'(insnLen), 32'd2);
    checkValue("popix.const.raddr", 32'(raddr), 32'hFFF0);
    checkValue("popix.const.rdata2", 32'(rdata2), 32'h12);
    checkValue("popix.const.ixout", 32'(ixOut), 32'h1234);
    applyStimulus("popix.after", 0, 0, 8'h00, 0, 16'h0, 8'h0, 0);

    // Orphan events in IDLE
    applyStimulus("orphan", 0, 1, 8'hAA, 0, 16'h0, 8'h0, 0);
    applyStimulus("orphan", 0, 0, 8'h00, 1, 16'h1111, 8'h22, 0);
    applyStimulus("orphan", 0, 1, 8'hBB, 1, 16'h3333, 8'h44, 1);
    checkValue("orphan.const.insn", insn, 32'h0000E1DD);

    // Back-to-back: retire A + start B + fetch 00
    validCount = 0;
    applyStimulus("b2b", 1, 1, 8'h3E, 0, 16'h0, 8'h0, 0);
    applyStimulus("b2b", 0, 1, 8'h7F, 1, 16'h2000, 8'h99, 0);
    ipNow = 16'h0200;
    applyStimulus("b2b", 1, 1, 8'h00, 0, 16'h0, 8'h0, 1);
    checkValue("b2b.const.lenA", 32'(insnLen), 32'd2);
    applyStimulus("b2b", 0, 0, 8'h00, 0, 16'h0, 8'h0, 1);
    checkValue("b2b.const.lenB", 32'(insnLen), 32'd1);
    checkValue("b2b.const.pulses", 32'(validCount), 32'd2);

    // Overflow: five fetches, three reads
    applyStimulus("ovf", 1, 1, 8'h11, 0, 16'h0, 8'h0, 0);
    applyStimulus("ovf", 0, 1, 8'h22, 1, 16'h0010, 8'hA1, 0);
    applyStimulus("ovf", 0, 1, 8'h33, 1, 16'h0011, 8'hA2, 0);
    applyStimulus("ovf", 0, 1, 8'h44, 1, 16'h0012, 8'hA3, 0);
    applyStimulus("ovf", 0, 1, 8'h55, 0, 16'h0, 8'h0, 1);
    checkValue("ovf.const.insn", insn, 32'h44332211);
    checkValue("ovf.const.len", 32'(insnLen), 32'd4);
    checkValue("ovf.const.rdata2", 32'(rdata2), 32'hA2);
    checkValue("ovf.const.flag", 32'(overflow), 32'd1);

    // Reset mid-capture
    validCount = 0;
    applyStimulus("rst", 1, 1, 8'hED, 0, 16'h0, 8'h0, 0);
    applyStimulus("rst", 0, 1, 8'hB0, 0, 16'h0, 8'h0, 0);
    doReset();
    applyStimulus("rst.after", 0, 1, 8'h01, 0, 16'h0, 8'h0, 1);
    applyStimulus("rst.new", 1, 1, 8'h76, 0, 16'h0, 8'h0, 0);
    applyStimulus("rst.new", 0, 0, 8'h00, 0, 16'h0, 8'h0, 1);
    checkValue("rst.const.len", 32'(insnLen), 32'd1);
    checkValue("rst.const.pulses", 32'(validCount), 32'd1);

    // Restart abandons the first capture
    validCount = 0;
    applyStimulus("restart", 1, 0, 8'h00, 0, 16'h0, 8'h0, 0);
    applyStimulus("restart", 0, 1, 8'hCB, 0, 16'h0, 8'h0, 0);
    applyStimulus("restart", 1, 0, 8'h00, 0, 16'h0, 8'h0, 0);
    applyStimulus("restart", 0, 1, 8'h00, 0, 16'h0, 8'h0, 0);
    applyStimulus("restart", 0, 0, 8'h00, 0, 16'h0, 8'h0, 1);
    applyStimulus("restart", 0, 0, 8'h00, 0, 16'h0, 8'h0, 0);
    checkValue("restart.const.insn", insn, 32'h00000000);
    checkValue("restart.const.len", 32'(insnLen), 32'd1);
    checkValue("restart.const.pulses", 32'(validCount), 32'd1);

    // Random event streams
    startCount = 0;
    for (int i = 0; i < 400; i++) begin
      ipNow = 16'($urandom); spNow = 16'($urandom);
      ixNow = 16'($urandom); iyNow = 16'($urandom);
      applyStimulus("rand",
                    ($urandom_range(0, 5) == 0), ($urandom_range(0, 1) == 1), 8'($urandom),
                    ($urandom_range(0, 2) == 0), 16'($urandom), 8'($urandom),
                    ($urandom_range(0, 6) == 0));
      if (i == 200) doReset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
